// File: rtl/cut_pattern_sequencer.sv
// LFSR-driven pattern sequencer for a 32-in/32-out combinational CUT; folds CUT responses into a MISR.
// Optional golden-signature comparator is built when CUT_SEQ_GOLDEN_CMP_EN is defined.
module cut_pattern_sequencer #(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      CNT_W  = 16,
  parameter int unsigned      SETTLE = 2,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(32'h04C11DB7)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] cut_in,
  input  logic [WIDTH-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pat_count,
  output logic [WIDTH-1:0] signature
`ifdef CUT_SEQ_GOLDEN_CMP_EN
  ,
  input  logic [WIDTH-1:0] golden,
  output logic             pass
`endif
);

  localparam int unsigned       SCNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  misr_q, misr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [SCNT_W-1:0] settle_q, settle_d;
`ifdef CUT_SEQ_GOLDEN_CMP_EN
  logic              pass_q, pass_d;
`endif

  // One Galois shift step; LFSR and MISR share the same polynomial.
  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    settle_d = settle_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          misr_d = '0;
          cnt_d  = '0;
          if (num_patterns != '0) begin
            target_d = num_patterns;
            lfsr_d   = (seed == '0) ? WIDTH'(1) : seed;
            settle_d = '0;
            state_d  = S_APPLY;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = S_CAPTURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      S_CAPTURE: begin
        misr_d = galois_step(misr_q) ^ cut_out;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_d == target_q) begin
          state_d = S_DONE;
        end else begin
          lfsr_d  = galois_step(lfsr_q);
          state_d = S_APPLY;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

`ifdef CUT_SEQ_GOLDEN_CMP_EN
  // Verdict is taken from the final signature on the edge that enters DONE, so it is valid with done.
  always_comb begin
    pass_d = pass_q;
    if (state_q == S_IDLE && start) begin
      pass_d = 1'b0;
    end
    if (state_d == S_DONE && state_q != S_DONE) begin
      pass_d = (misr_d == golden);
    end
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= '0;
      misr_q   <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      settle_q <= '0;
`ifdef CUT_SEQ_GOLDEN_CMP_EN
      pass_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      settle_q <= settle_d;
`ifdef CUT_SEQ_GOLDEN_CMP_EN
      pass_q   <= pass_d;
`endif
    end
  end

  assign cut_in    = lfsr_q;
  assign signature = misr_q;
  assign pat_count = cnt_q;
  assign busy      = (state_q == S_APPLY) || (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);
`ifdef CUT_SEQ_GOLDEN_CMP_EN
  assign pass      = pass_q;
`endif

endmodule

// File: doc/cut_pattern_sequencer.md
# cut_pattern_sequencer

Sequential test controller for the 32-in/32-out combinational benchmark circuits under test (CUT). Generates pseudo-random input vectors with an LFSR and drives them onto the CUT inputs. After each vector it waits a programmable settle time, then folds the CUT outputs into a MISR signature. It sits between the bench/host control interface and one CUT instance, and sequences a complete run from a single start pulse.

## Interface
- `WIDTH`, 32, CUT input/output bus width (LFSR and MISR width).
- `CNT_W`, 16, width of the pattern counter.
- `SETTLE`, 2, cycles a vector is held before capture; legal range ≥1.
- `POLY`, 32'h04C11DB7, Galois feedback polynomial shared by LFSR and MISR.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `num_patterns`  in  CNT_W  vectors per run; latched at start.
- `seed`  in  WIDTH  LFSR seed; latched at start; 0 is replaced by 1.
- `cut_in`  out  WIDTH  vector driven to the CUT inputs (registered).
- `cut_out`  in  WIDTH  CUT response.
- `busy`  out  1  high in APPLY and CAPTURE.
- `done`  out  1  one-cycle pulse at end of run.
- `pat_count`  out  CNT_W  vectors captured in current/last run.
- `signature`  out  WIDTH  MISR value; held after done until next start.
- `golden`  in  WIDTH  expected signature (only with macro).
- `pass`  out  1  signature==golden, valid from done (only with macro).

## Operation
- FSM states: IDLE, APPLY, CAPTURE, DONE.
- IDLE + `start`=1, `num_patterns`≠0: latch count; `lfsr`←seed (or 1 if 0); `misr`←0; `pat_count`←0; go to APPLY.
- IDLE + `start`=1, `num_patterns`=0: `misr`←0; `pat_count`←0; go to DONE.
- APPLY: `cut_in`=`lfsr`; settle counter runs from 0 to SETTLE-1, then go to CAPTURE.
- CAPTURE: `misr`←(`misr`<<1) ^ (`misr`[WIDTH-1] ? POLY : 0) ^ `cut_out`; `pat_count`+1.
  - If new count == latched count, go to DONE.
  - Otherwise `lfsr`←(`lfsr`<<1) ^ (`lfsr`[WIDTH-1] ? POLY : 0) and go to APPLY.
- DONE: `done`=1 for this cycle only; next state is IDLE.
- `start` is ignored outside IDLE; `num_patterns` and `seed` changes after latching have no effect.
- `pat_count` wraps modulo 2^CNT_W. The latched count bounds the run, so it never wraps within a run.
- Reset value of every output is 0, including `cut_in`, `signature`, `pat_count` and `pass`. The FSM resets to IDLE.
- Reset mid-run aborts immediately: no `done` pulse, and the signature is cleared.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Pattern k (k from 0) is driven on `cut_in` from cycle 1+k·(SETTLE+1), for SETTLE+1 cycles.
- Capture happens at cycle (k+1)·(SETTLE+1).
- `done` is high in cycle N·(SETTLE+1)+1; for N=0 it is high in cycle 1.
- `signature` and `pat_count` are final in the `done` cycle.
- `cut_out` must be stable SETTLE cycles after `cut_in` changes (CUT combinational depth is budgeted by SETTLE).
- `start` high in the `done` cycle is ignored; it is accepted again from the following cycle (IDLE).

## Configuration
- Macro `CUT_SEQ_GOLDEN_CMP_EN` defined:
  - `golden` input and `pass` output exist.
  - `pass` is registered with `signature`==`golden`, updated in the `done` cycle and held until the next start, where it clears to 0.
- Macro undefined: no `golden` port and no `pass` port; there is no comparator logic.

## Test plan
- SETTLE=2, seed=1, N=1, `cut_out`=0 → `cut_in`=1 in cycles 1-3; `done` in cycle 4; `signature`=0; `pat_count`=1.
- N=2, seed=1, `cut_out`=32'hFFFFFFFF → `cut_in` sequence 1, 2; `signature`=32'h04C11DB6; `done` in cycle 7.
- seed=0, N=3, `cut_out`=0 → `cut_in` sequence 1, 2, 4; `signature`=0; `pat_count`=3.
- N=0 → `done` in cycle 1; `busy` never high; `signature`=0.
- N=4 run:
  - `start` pulses at cycles 2 and 5 → ignored, with a single `done`.
  - `rst_n` low at cycle 5 → all outputs 0 next cycle and no `done`.
- Macro on, N=2, `cut_out`=32'hFFFFFFFF:
  - `golden`=32'h04C11DB6 → `pass`=1.
  - `golden`=0 → `pass`=0.
